timebase_generator: RTL and testbench
=====================================

# timebase_generator

Parametrised free-running timebase for the pendulum design. It divides `CLK_50` down to a microsecond count and derives a coarser programmable period tick, for example milliseconds for the display and sampling logic. It adds run/pause, synchronous clear, a sticky wrap flag and an optional snapshot capture port. Consumers use the single-cycle strobes as clock enables, never as clocks.

## Interface
Parameters:
- `CLK_DIV`, default 50: `CLK_50` cycles per microsecond tick; legal range ≥ 2.
- `WIDTH`, default 32: width of `microseconds`, `period_count` and `capture_value`.
- `PERIOD_US`, default 1000: microseconds per period tick; legal range ≥ 2.

Ports:
- `CLK_50`  in  1  system clock; one clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `enable`  in  1  1 = timebase runs; 0 = all state held.
- `clear`  in  1  synchronous zeroing of all counters and flags.
- `capture`  in  1  snapshot request, single-cycle or level.
- `microseconds`  out  WIDTH  elapsed microseconds.
- `tick_us`  out  1  one-cycle strobe in the cycle `microseconds` shows a new value.
- `period_count`  out  WIDTH  elapsed periods of PERIOD_US.
- `tick_period`  out  1  one-cycle strobe in the cycle `period_count` shows a new value.
- `wrap`  out  1  sticky; `microseconds` has rolled over.
- `capture_value`  out  WIDTH  last snapshot of `microseconds`.
- `capture_valid`  out  1  one-cycle strobe: `capture_value` updated.

## Operation
- Internal prescaler `pre` counts 0..CLK_DIV-1. Internal period counter `pcnt` counts 0..PERIOD_US-1.
- Priority on each edge, highest first: `reset`, then `clear`, then counting.
- `reset`:
  - Zeroes `pre`, `pcnt`, `microseconds`, `period_count` and `capture_value`.
  - Drives `wrap`, `tick_us`, `tick_period` and `capture_valid` to 0.
- `clear`: same effect as reset on everything except `capture_value` and `capture_valid`, which follow the capture rules.
- Counting, when `enable`=1:
  - If `pre`≠CLK_DIV-1, `pre` increments.
  - Otherwise `pre`←0, `microseconds`←`microseconds`+1 modulo 2^WIDTH, and `tick_us`←1.
  - On that µs edge, if `pcnt`=PERIOD_US-1: `pcnt`←0, `period_count`+1 modulo 2^WIDTH, `tick_period`←1. Otherwise `pcnt`+1.
  - If `microseconds` was all-ones on that µs edge, `wrap`←1. It stays set until `reset` or `clear`.
- `enable`=0: `pre`, `pcnt` and all counts hold; `tick_us` and `tick_period` are 0. When `enable` returns to 1, the prescaler phase resumes where it stopped.
- Strobes are 0 on every cycle not named above.
- Capture (see Configuration):
  - On an edge where `capture`=1, `capture_value` takes the value of `microseconds` visible in that cycle. This is the pre-increment value on a µs edge and the pre-clear value on a `clear` edge.
  - `capture_valid`←1 on that edge, 0 otherwise.
  - Capture works regardless of `enable`.
  - A level-held `capture` re-captures every cycle.

## Timing
- All outputs are registered; no combinational input-to-output path.
- With `enable`=1 held from the first cycle after `reset` deasserts:
  - `tick_us` first high, with `microseconds`=1, CLK_DIV cycles later.
  - Subsequent `tick_us` strobes every CLK_DIV cycles.
- `tick_period` coincides with the `tick_us` that completes each PERIOD_US-th microsecond. The period is CLK_DIV×PERIOD_US cycles.
- `capture_value` and `capture_valid` are valid 1 cycle after the `capture` edge.
- `clear` or `reset` asserted mid-operation takes effect at the next edge, including on a µs/period edge. The pending increment and strobe are discarded.

## Configuration
- `TIMEBASE_CAPTURE_EN` defined: capture logic is built as described in Operation.
- `TIMEBASE_CAPTURE_EN` undefined:
  - The `capture` input is ignored.
  - `capture_value` is constant 0 and `capture_valid` is constant 0.
  - No capture registers are synthesised.
  - All other behaviour is identical.

## Test plan
- Reset release, CLK_DIV=50, `enable`=1 → `microseconds`=1 and `tick_us`=1 exactly 50 cycles after release; `microseconds`=3 after 150 cycles; `tick_us` is never high two cycles in a row.
- PERIOD_US=4, CLK_DIV=5 → `tick_period` every 20 cycles; `period_count`=2 at cycle 40; `microseconds`=8 at the same edge.
- WIDTH=4 → after 16 µs, `microseconds`=0 and `wrap`=1; `wrap` stays 1 across further counting; pulse `clear` → all counters 0 and `wrap`=0 next cycle.
- Pause: drop `enable` for 37 cycles mid-prescale → all outputs frozen, no strobes; resumed `tick_us` occurs exactly 37 cycles later than the uninterrupted schedule.
- Capture on a µs edge with `microseconds`=9 becoming 10 → `capture_value`=9 and `capture_valid`=1 for one cycle. Capture with `enable`=0 and `microseconds`=12 → `capture_value`=12. With the macro undefined → `capture_valid` stays 0.
- `clear` and `reset` coinciding with a `tick_period` edge → next cycle all counts 0 and no strobe; `reset` while `capture`=1 → `capture_value`=0 and `capture_valid`=0.

Source files
------------

// File: rtl/timebase_generator.sv
// -----------------------------------------------------------------------------
// timebase_generator
//
// Purpose:
//   A free-running timebase for the pendulum design. The system clock is
//   divided down to a microsecond count. A coarser programmable period count
//   (milliseconds by default) is derived from that microsecond count. The
//   timebase supports run/pause, synchronous clear, a sticky wrap flag and an
//   optional snapshot capture port. The single-cycle strobes are intended as
//   clock enables for downstream logic. They must never be used as clocks.
//
// Parameters:
//   CLK_DIV   - CLK_50 cycles per microsecond tick (>= 2)
//   WIDTH     - width of microseconds, period_count and capture_value
//   PERIOD_US - microseconds per period tick (>= 2)
//
// Ports:
//   CLK_50        in   1      system clock (single domain)
//   reset         in   1      synchronous, active-high reset
//   enable        in   1      1 = run, 0 = hold all state
//   clear         in   1      synchronous zeroing of counters and flags
//   capture       in   1      snapshot request (pulse or level)
//   microseconds  out  WIDTH  elapsed microseconds
//   tick_us       out  1      strobe: microseconds just changed
//   period_count  out  WIDTH  elapsed periods of PERIOD_US
//   tick_period   out  1      strobe: period_count just changed
//   wrap          out  1      sticky: microseconds has rolled over
//   capture_value out  WIDTH  last snapshot of microseconds
//   capture_valid out  1      strobe: capture_value just updated
//
// Build option:
//   TIMEBASE_CAPTURE_EN - when defined, the capture registers are built.
//   When the macro is undefined, capture is ignored and capture_value and
//   capture_valid are tied to 0.
// -----------------------------------------------------------------------------
module timebase_generator #(
  parameter int CLK_DIV   = 50,
  parameter int WIDTH     = 32,
  parameter int PERIOD_US = 1000
) (
  input  logic             CLK_50,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic             capture,
  output logic [WIDTH-1:0] microseconds,
  output logic             tick_us,
  output logic [WIDTH-1:0] period_count,
  output logic             tick_period,
  output logic             wrap,
  output logic [WIDTH-1:0] capture_value,
  output logic             capture_valid
);

  // Counter widths are sized to hold the terminal count. The widths are
  // clamped to at least 1 bit so that degenerate parameter values still
  // elaborate.
  localparam int PRE_W  = (CLK_DIV   > 1) ? $clog2(CLK_DIV)   : 1;
  localparam int PCNT_W = (PERIOD_US > 1) ? $clog2(PERIOD_US) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(CLK_DIV - 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PERIOD_US - 1);

  // ---------------------------------------------------------------------------
  // Timebase state
  // ---------------------------------------------------------------------------
  logic [PRE_W-1:0]  pre_q,          pre_d;
  logic [PCNT_W-1:0] pcnt_q,         pcnt_d;
  logic [WIDTH-1:0]  microseconds_q, microseconds_d;
  logic [WIDTH-1:0]  period_count_q, period_count_d;
  logic              tick_us_q,      tick_us_d;
  logic              tick_period_q,  tick_period_d;
  logic              wrap_q,         wrap_d;

  logic us_edge;
  logic period_edge;

  // A microsecond edge occurs only when the prescaler is allowed to advance
  // from its terminal count. A period edge is a microsecond edge that also
  // completes the period.
  assign us_edge     = enable && (pre_q == PRE_LAST);
  assign period_edge = us_edge && (pcnt_q == PCNT_LAST);

  always_comb begin
    pre_d          = pre_q;
    pcnt_d         = pcnt_q;
    microseconds_d = microseconds_q;
    period_count_d = period_count_q;
    tick_us_d      = 1'b0;
    tick_period_d  = 1'b0;
    wrap_d         = wrap_q;

    if (clear) begin
      // Clear takes priority over counting. Any increment or strobe that
      // would have happened on this edge is dropped.
      pre_d          = '0;
      pcnt_d         = '0;
      microseconds_d = '0;
      period_count_d = '0;
      wrap_d         = 1'b0;
    end else if (enable) begin
      if (us_edge) begin
        pre_d          = '0;
        microseconds_d = microseconds_q + WIDTH'(1);
        tick_us_d      = 1'b1;
        // Roll-over is detected from the value before the increment.
        if (&microseconds_q) begin
          wrap_d = 1'b1;
        end
        if (period_edge) begin
          pcnt_d         = '0;
          period_count_d = period_count_q + WIDTH'(1);
          tick_period_d  = 1'b1;
        end else begin
          pcnt_d = pcnt_q + PCNT_W'(1);
        end
      end else begin
        pre_d = pre_q + PRE_W'(1);
      end
    end
    // When enable is low, every count holds its value and both strobes stay
    // at their default of 0. The prescaler phase is therefore preserved
    // across a pause.
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      pre_q          <= '0;
      pcnt_q         <= '0;
      microseconds_q <= '0;
      period_count_q <= '0;
      tick_us_q      <= 1'b0;
      tick_period_q  <= 1'b0;
      wrap_q         <= 1'b0;
    end else begin
      pre_q          <= pre_d;
      pcnt_q         <= pcnt_d;
      microseconds_q <= microseconds_d;
      period_count_q <= period_count_d;
      tick_us_q      <= tick_us_d;
      tick_period_q  <= tick_period_d;
      wrap_q         <= wrap_d;
    end
  end

  assign microseconds = microseconds_q;
  assign period_count = period_count_q;
  assign tick_us      = tick_us_q;
  assign tick_period  = tick_period_q;
  assign wrap         = wrap_q;

  // ---------------------------------------------------------------------------
  // Snapshot capture
  // ---------------------------------------------------------------------------
`ifdef TIMEBASE_CAPTURE_EN
  logic [WIDTH-1:0] capture_value_q, capture_value_d;
  logic             capture_valid_q, capture_valid_d;

  // The snapshot samples the registered count that is visible in this
  // cycle. On a microsecond edge, this is the value before the increment.
  // On a clear edge, this is the value before the clear. Capture does not
  // depend on enable.
  always_comb begin
    capture_value_d = capture_value_q;
    capture_valid_d = 1'b0;
    if (capture) begin
      capture_value_d = microseconds_q;
      capture_valid_d = 1'b1;
    end
  end

  always_ff @(posedge CLK_50) begin
    if (reset) begin
      capture_value_q <= '0;
      capture_valid_q <= 1'b0;
    end else begin
      capture_value_q <= capture_value_d;
      capture_valid_q <= capture_valid_d;
    end
  end

  assign capture_value = capture_value_q;
  assign capture_valid = capture_valid_q;
`else
  // Capture is not built in this configuration. The input is consumed here
  // so that it is not left dangling.
  logic unused_capture;
  assign unused_capture = capture;

  assign capture_value = '0;
  assign capture_valid = 1'b0;
`endif

endmodule

// File: tb/tb_timebase_generator.sv
// -----------------------------------------------------------------------------
// tb_timebase_generator
//
// Drives two instances of timebase_generator from shared inputs:
//   dut_a - default parameters (CLK_DIV=50, WIDTH=32, PERIOD_US=1000)
//   dut_b - small configuration (CLK_DIV=5, WIDTH=4, PERIOD_US=4)
//
// Each instance has its own reference model. The model keeps only the number
// of enabled clock cycles since the last reset or clear. Every output is
// derived from that number with plain division and modulo arithmetic.
// -----------------------------------------------------------------------------
module tb_timebase_generator;

`ifdef TIMEBASE_CAPTURE_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  localparam int A_DIV = 50, A_W = 32, A_PER = 1000;
  localparam int B_DIV = 5,  B_W = 4,  B_PER = 4;

  logic clk = 1'b0;
  logic reset = 1'b1, enable = 1'b0, clear = 1'b0, capture = 1'b0;

  logic [A_W-1:0] us_a, pc_a, cv_a;
  logic           tu_a, tp_a, wr_a, cvv_a;
  logic [B_W-1:0] us_b, pc_b, cv_b;
  logic           tu_b, tp_b, wr_b, cvv_b;

  always #5 clk = ~clk;

  timebase_generator #(.CLK_DIV(A_DIV), .WIDTH(A_W), .PERIOD_US(A_PER)) dut_a (
    .CLK_50(clk), .reset(reset), .enable(enable), .clear(clear), .capture(capture),
    .microseconds(us_a), .tick_us(tu_a), .period_count(pc_a), .tick_period(tp_a),
    .wrap(wr_a), .capture_value(cv_a), .capture_valid(cvv_a)
  );

  timebase_generator #(.CLK_DIV(B_DIV), .WIDTH(B_W), .PERIOD_US(B_PER)) dut_b (
    .CLK_50(clk), .reset(reset), .enable(enable), .clear(clear), .capture(capture),
    .microseconds(us_b), .tick_us(tu_b), .period_count(pc_b), .tick_period(tp_b),
    .wrap(wr_b), .capture_value(cv_b), .capture_valid(cvv_b)
  );

  int checks = 0;
  int errors = 0;

  // Model state, one set per instance.
  longint n_a = 0, n_b = 0;       // enabled cycles since reset or clear
  bit     mtu_a, mtp_a, mtu_b, mtp_b;
  longint mcv_a = 0, mcv_b = 0;
  bit     mcvv_a, mcvv_b;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint m_us(input longint n, input int cd, input int w);
    return (n / cd) % (longint'(1) << w);
  endfunction

  function automatic longint m_pc(input longint n, input int cd, input int pu, input int w);
    return (n / (cd * pu)) % (longint'(1) << w);
  endfunction

  function automatic bit m_wrap(input longint n, input int cd, input int w);
    return (n / cd) >= (longint'(1) << w);
  endfunction

  // Applies one clock edge to a model instance.
  task automatic model_edge(input int cd, input int pu, input int w,
                            input bit r, input bit e, input bit c, input bit cp,
                            inout longint n, output bit tu, output bit tp,
                            inout longint cv, output bit cvv);
    tu  = 1'b0;
    tp  = 1'b0;
    cvv = 1'b0;
    if (r) begin
      n  = 0;
      cv = 0;
    end else begin
      if (cp && CAP_EN) begin
        cv  = m_us(n, cd, w);
        cvv = 1'b1;
      end
      if (c) begin
        n = 0;
      end else if (e) begin
        n++;
        tu = (n % cd) == 0;
        tp = (n % (cd * pu)) == 0;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " us_a"},  us_a,  m_us(n_a, A_DIV, A_W));
    chk({tag, " pc_a"},  pc_a,  m_pc(n_a, A_DIV, A_PER, A_W));
    chk({tag, " tu_a"},  tu_a,  mtu_a);
    chk({tag, " tp_a"},  tp_a,  mtp_a);
    chk({tag, " wr_a"},  wr_a,  m_wrap(n_a, A_DIV, A_W));
    chk({tag, " cv_a"},  cv_a,  mcv_a);
    chk({tag, " cvv_a"}, cvv_a, mcvv_a);
    chk({tag, " us_b"},  us_b,  m_us(n_b, B_DIV, B_W));
    chk({tag, " pc_b"},  pc_b,  m_pc(n_b, B_DIV, B_PER, B_W));
    chk({tag, " tu_b"},  tu_b,  mtu_b);
    chk({tag, " tp_b"},  tp_b,  mtp_b);
    chk({tag, " wr_b"},  wr_b,  m_wrap(n_b, B_DIV, B_W));
    chk({tag, " cv_b"},  cv_b,  mcv_b);
    chk({tag, " cvv_b"}, cvv_b, mcvv_b);
  endtask

  // Drives the inputs for one cycle, advances both models on the edge, and
  // then checks every output 1 ns after the edge.
  task automatic step(input bit r, input bit e, input bit c, input bit cp, input string tag);
    reset = r; enable = e; clear = c; capture = cp;
    @(posedge clk);
    model_edge(A_DIV, A_PER, A_W, r, e, c, cp, n_a, mtu_a, mtp_a, mcv_a, mcvv_a);
    model_edge(B_DIV, B_PER, B_W, r, e, c, cp, n_b, mtu_b, mtp_b, mcv_b, mcvv_b);
    #1;
    check_model(tag);
  endtask

  typedef struct {
    bit r, e, c, cp;
    int cycles;
    int us, tu, pc, tp, wr;   // dut_b outputs after the last cycle
  } vec_t;

  vec_t vecs[9];

  initial begin
    bit prev_tu;

    // Expected dut_b values are hand-derived for CLK_DIV=5, PERIOD_US=4, WIDTH=4.
    vecs[0] = '{1, 0, 0, 0, 2,  0, 0, 0, 0, 0}; // reset state
    vecs[1] = '{0, 1, 0, 0, 5,  1, 1, 0, 0, 0}; // first us tick at cycle 5
    vecs[2] = '{0, 1, 0, 0, 15, 4, 1, 1, 1, 0}; // cycle 20: first period tick
    vecs[3] = '{0, 1, 0, 0, 20, 8, 1, 2, 1, 0}; // cycle 40: period_count=2, us=8
    vecs[4] = '{0, 1, 0, 0, 1,  8, 0, 2, 0, 0}; // strobes last one cycle
    vecs[5] = '{0, 1, 0, 0, 39, 0, 1, 4, 1, 1}; // cycle 80: 16 us, wrapped
    vecs[6] = '{0, 1, 0, 0, 5,  1, 1, 4, 0, 1}; // wrap is sticky
    vecs[7] = '{0, 1, 1, 0, 1,  0, 0, 0, 0, 0}; // clear zeroes everything
    vecs[8] = '{0, 0, 0, 0, 3,  0, 0, 0, 0, 0}; // idle while disabled

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].cycles; k++)
        step(vecs[i].r, vecs[i].e, vecs[i].c, vecs[i].cp, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d us_b", i), us_b, vecs[i].us);
      chk($sformatf("vec%0d tick_us_b", i), tu_b, vecs[i].tu);
      chk($sformatf("vec%0d period_count_b", i), pc_b, vecs[i].pc);
      chk($sformatf("vec%0d tick_period_b", i), tp_b, vecs[i].tp);
      chk($sformatf("vec%0d wrap_b", i), wr_b, vecs[i].wr);
      $display("vector %0d applied: us_b=%0d pc_b=%0d wrap_b=%0d", i, us_b, pc_b, wr_b);
    end

    // Default configuration: first tick 50 cycles after reset release, and
    // no two consecutive tick_us cycles.
    step(1, 0, 0, 0, "rstA");
    prev_tu = 1'b0;
    for (int k = 1; k <= 150; k++) begin
      step(0, 1, 0, 0, "runA");
      chk("tick_us_a back-to-back", prev_tu & tu_a, 0);
      prev_tu = tu_a;
      if (k == 49) chk("tick_us_a early", tu_a, 0);
      if (k == 50) begin
        chk("us_a at 50", us_a, 1);
        chk("tick_us_a at 50", tu_a, 1);
      end
    end
    chk("us_a at 150", us_a, 3);
    $display("default config: us_a=%0d after 150 cycles", us_a);

    // Pause for 37 cycles in the middle of a prescale. The tick is delayed
    // by exactly 37 cycles.
    step(0, 1, 1, 0, "clrP");
    for (int k = 0; k < 7; k++) step(0, 1, 0, 0, "preP");
    for (int k = 0; k < 37; k++) begin
      step(0, 0, 0, 0, "pause");
      chk("pause us_b frozen", us_b, 1);
      chk("pause tick_us_b", tu_b, 0);
    end
    step(0, 1, 0, 0, "res1");
    step(0, 1, 0, 0, "res2");
    chk("resume early tick", tu_b, 0);
    step(0, 1, 0, 0, "res3");
    chk("resume tick_us_b", tu_b, 1);
    chk("resume us_b", us_b, 2);
    $display("pause: resumed tick_us_b=%0d us_b=%0d", tu_b, us_b);

    // Capture on the 9 -> 10 microsecond edge, and capture while disabled.
    step(0, 1, 1, 0, "clrC");
    for (int k = 0; k < 49; k++) step(0, 1, 0, 0, "preC");
    chk("pre-capture us_b", us_b, 9);
    step(0, 1, 0, 1, "cap9");
    chk("capture us_b", us_b, 10);
    chk("capture_value_b on us edge", cv_b, CAP_EN ? 9 : 0);
    chk("capture_valid_b", cvv_b, CAP_EN ? 1 : 0);
    step(0, 1, 0, 0, "capoff");
    chk("capture_valid_b one cycle", cvv_b, 0);
    for (int k = 0; k < 9; k++) step(0, 1, 0, 0, "toC12");
    chk("us_b before idle capture", us_b, 12);
    step(0, 0, 0, 1, "cap12");
    chk("capture_value_b disabled", cv_b, CAP_EN ? 12 : 0);
    $display("capture: cv_b=%0d cvv_b=%0d", cv_b, cvv_b);

    // Clear and reset that land on a period edge.
    step(0, 1, 1, 0, "clrE");
    for (int k = 0; k < 19; k++) step(0, 1, 0, 0, "toEdge1");
    step(0, 1, 1, 0, "clrEdge");
    chk("clear@edge us_b", us_b, 0);
    chk("clear@edge pc_b", pc_b, 0);
    chk("clear@edge tick_us_b", tu_b, 0);
    chk("clear@edge tick_period_b", tp_b, 0);
    for (int k = 0; k < 20; k++) step(0, 1, 0, 0, "toEdge2");
    chk("before rst capture_value_b", cv_b, CAP_EN ? 12 : 0);
    for (int k = 0; k < 19; k++) step(0, 1, 0, 0, "toEdge3");
    step(1, 1, 0, 1, "rstEdge");
    chk("rst@edge us_b", us_b, 0);
    chk("rst@edge pc_b", pc_b, 0);
    chk("rst@edge tick_period_b", tp_b, 0);
    chk("rst capture_value_b", cv_b, 0);
    chk("rst capture_valid_b", cvv_b, 0);
    $display("edge clear/reset: us_b=%0d pc_b=%0d cv_b=%0d", us_b, pc_b, cv_b);

    // Randomized operation checked against the models.
    for (int k = 0; k < 3000; k++) begin
      step($urandom_range(0, 127) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 255) == 0, $urandom_range(0, 3) == 0, "rand");
    end
    $display("random phase done: us_b=%0d pc_b=%0d wrap_b=%0d", us_b, pc_b, wr_b);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
